// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Two-port arbiter/sequencer in front of a single-ported data memory.
// Port 0 is the core load/store unit and port 1 is the debug/loader port.
// One transaction is accepted at a time. The request fields are latched at
// grant, driven onto the memory interface, and the read word is captured
// READ_LAT cycles after the issue cycle. It is returned with a one-cycle ack.
//
// Sequence: IDLE -> ISSUE -> (reads: WAIT x READ_LAT) -> RESP -> IDLE
//   write ack : cycle 2 after the request is seen in IDLE
//   read ack  : cycle 2 + READ_LAT after the request is seen in IDLE
//
// Build option:
//   DMEM_ARB_RR_EN defined   : round-robin arbitration with a 1-bit pointer.
//                              The pointer resets to 0, so port 0 is preferred.
//   DMEM_ARB_RR_EN undefined : fixed priority, and port 0 always wins.
//
// Parameters:
//   ADDR_W    address width
//   DATA_W    data width
//   READ_LAT  cycles after ISSUE before mem_read_data is valid (0..7)
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   pN_req/we/addr/wdata        port N request; req is held high until pN_ack
//   pN_ack, pN_rdata            one-cycle completion pulse; read data is valid
//                               with the ack, and is 0 for writes
//   mem_address/mem_write_data  memory address and write data; each holds the
//                               last latched value
//   mem_MemRead/mem_MemWrite    memory strobes
//   mem_read_data               memory read data
//   busy                        high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    input  logic [DATA_W-1:0] mem_read_data,

    output logic              busy
);

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    // Transaction fields latched at grant. Later changes on the port pins are
    // ignored until the next grant.
    logic              lat_we;
    logic              lat_port;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt;

    logic              any_req;
    logic              grant_port;

    assign any_req = p0_req | p1_req;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef DMEM_ARB_RR_EN
    logic rr_ptr;

    // A lone requester always wins. On a tie, the pointer names the preferred
    // port.
    always_comb begin
        grant_port = p1_req;
        if (p0_req && p1_req) begin
            grant_port = rr_ptr;
        end
    end

    // After every grant, the pointer moves to prefer the port that lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (state == S_IDLE && any_req) begin
            rr_ptr <= ~grant_port;
        end
    end
`else
    // Fixed priority: port 1 wins only when port 0 is not requesting.
    assign grant_port = p1_req & ~p0_req;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_next is given a default before the case statement. Every path
    // therefore assigns it, and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (lat_we || READ_LAT == 0) begin
                    state_next = S_RESP;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // The counter reaches zero on this edge, so the word is
                // captured here.
                if (cnt == CNT_W'(1)) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request latches, latency counter and read-data capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_port  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        lat_port  <= grant_port;
                        lat_we    <= grant_port ? p1_we    : p0_we;
                        lat_addr  <= grant_port ? p1_addr  : p0_addr;
                        lat_wdata <= grant_port ? p1_wdata : p0_wdata;
                    end
                end
                S_ISSUE: begin
                    if (lat_we) begin
                        // A write returns zero on its ack.
                        rdata_q <= '0;
                    end else if (READ_LAT == 0) begin
                        rdata_q <= mem_read_data;
                    end else begin
                        cnt <= LAT_LOAD;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        rdata_q <= mem_read_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The address and data ports come straight from the latches. They hold the
    // last granted values between transactions and read 0 after reset.
    assign mem_address    = lat_addr;
    assign mem_write_data = lat_wdata;
    assign mem_MemWrite   = (state == S_ISSUE) && lat_we;
    assign mem_MemRead    = ((state == S_ISSUE) && !lat_we) || (state == S_WAIT);
    assign busy           = (state != S_IDLE);

    assign p0_ack   = (state == S_RESP) && !lat_port;
    assign p1_ack   = (state == S_RESP) &&  lat_port;
    assign p0_rdata = p0_ack ? rdata_q : '0;
    assign p1_rdata = p1_ack ? rdata_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Self-checking bench for data_mem_arbiter.
//
// A small behavioural data memory with READ_LAT-cycle read latency stands in
// for data_mem. Outside a valid read window it returns a junk word.
//
// The reference model tracks:
//   - memory contents, as an array
//   - who wins each tie, from the arbitration rule
//   - when each ack is due:
//       * 2 cycles after the request is seen in IDLE for a write
//       * 2 + READ_LAT cycles for a read
//       * a losing port starts over in the IDLE cycle after the winner's ack
//
// Fields of a granted port are scrambled while its transaction is in flight,
// so any use of live port fields shows up as a wrong address, data or result.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

    localparam int LAT = 1;
    localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [63:0] p0_rdata, p1_rdata;
    logic [63:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_MemRead, mem_MemWrite;
    logic        busy;

    logic        init_en;
    logic [63:0] mem_arr [256];
    logic [63:0] ref_mem [256];
    logic [63:0] last_rdata;
`ifdef DMEM_ARB_RR_EN
    logic        ref_pref;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .READ_LAT(LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .p0_req         (p0_req),
        .p0_we          (p0_we),
        .p0_addr        (p0_addr),
        .p0_wdata       (p0_wdata),
        .p0_ack         (p0_ack),
        .p0_rdata       (p0_rdata),
        .p1_req         (p1_req),
        .p1_we          (p1_we),
        .p1_addr        (p1_addr),
        .p1_wdata       (p1_wdata),
        .p1_ack         (p1_ack),
        .p1_rdata       (p1_rdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_MemRead    (mem_MemRead),
        .mem_MemWrite   (mem_MemWrite),
        .mem_read_data  (mem_read_data),
        .busy           (busy)
    );

    function automatic logic [63:0] init_word(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'(i * 7 + 3)};
    endfunction

    // Behavioural data memory: writes commit on the edge.
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
        end else if (mem_MemWrite) begin
            mem_arr[mem_address[7:0]] <= mem_write_data;
        end
    end

    // Behavioural data memory: reads appear LAT cycles after they are sampled.
    generate
        if (LAT == 0) begin : g_rd_comb
            assign mem_read_data = mem_MemRead ? mem_arr[mem_address[7:0]] : JUNK;
        end else begin : g_rd_pipe
            logic [63:0] stg [LAT];
            always @(posedge clk) begin
                stg[0] <= mem_MemRead ? mem_arr[mem_address[7:0]] : JUNK;
                for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
            end
            assign mem_read_data = stg[LAT-1];
        end
    endgenerate

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Runs one request pattern. It is entered and left at a negedge while the
    // DUT is idle, and the current cycle is cycle 0.
    task automatic run_txn(input logic r0, input logic r1, input logic we0, input logic we1,
                           input logic [63:0] a0, input logic [63:0] a1,
                           input logic [63:0] d0, input logic [63:0] d1);
        logic [1:0]  pend;
        logic        cur, cwe;
        logic [63:0] ca, cd, got, exp_rd;
        int          cyc, exp_cyc, grant_cyc, wcnt, rcnt;

        pend = {r1, r0};
        p0_req = r0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
`ifdef DMEM_ARB_RR_EN
        cur = (r0 && r1) ? ref_pref : r1;
        ref_pref = ~cur;
`else
        cur = r1 && !r0;
`endif
        cwe = cur ? we1 : we0;
        ca  = cur ? a1  : a0;
        cd  = cur ? d1  : d0;
        grant_cyc = 0;
        exp_cyc   = 2 + (cwe ? 0 : LAT);
        cyc = 0; wcnt = 0; rcnt = 0;

        while (pend != 2'b00 && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (mem_MemWrite) wcnt++;
            if (mem_MemRead)  rcnt++;
            if (mem_MemRead || mem_MemWrite) check("mem_address", mem_address, ca);
            if (mem_MemWrite) check("mem_write_data", mem_write_data, cd);
            if (p0_ack || p1_ack) begin
                check("ack_port",  64'(p1_ack), 64'(cur));
                check("ack_both",  64'(p0_ack & p1_ack), '0);
                check("ack_cycle", 64'(cyc), 64'(exp_cyc));
                check("write_strobe_cycles", 64'(wcnt), 64'(cwe ? 1 : 0));
                check("read_strobe_cycles",  64'(rcnt), 64'(cwe ? 0 : 1 + LAT));
                got = cur ? p1_rdata : p0_rdata;
                if (cwe) begin
                    ref_mem[ca[7:0]] = cd;
                    exp_rd = '0;
                end else begin
                    exp_rd = ref_mem[ca[7:0]];
                end
                check("ack_rdata", got, exp_rd);
                check("other_rdata", cur ? p0_rdata : p1_rdata, '0);
                last_rdata = got;
                pend[cur] = 1'b0;
                if (cur) p1_req = 1'b0; else p0_req = 1'b0;
                if (pend != 2'b00) begin
                    cur = ~cur;
`ifdef DMEM_ARB_RR_EN
                    ref_pref = ~cur;
`endif
                    cwe = cur ? we1 : we0;
                    ca  = cur ? a1  : a0;
                    cd  = cur ? d1  : d0;
                    grant_cyc = cyc + 1;
                    exp_cyc   = grant_cyc + 2 + (cwe ? 0 : LAT);
                    wcnt = 0; rcnt = 0;
                end
            end else if (cyc >= grant_cyc + 1) begin
                // The in-flight port may change its pins freely.
                if (cur) begin
                    p1_addr = {$urandom, $urandom}; p1_wdata = {$urandom, $urandom}; p1_we = 1'($urandom);
                end else begin
                    p0_addr = {$urandom, $urandom}; p0_wdata = {$urandom, $urandom}; p0_we = 1'($urandom);
                end
            end
        end
        check("txn_timeout_pending", 64'(pend), '0);
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_busy", 64'(busy), '0);
        check("idle_acks", 64'({p0_ack, p1_ack}), '0);
    endtask

    initial begin
        logic [1:0]  sel;
        logic [63:0] ra0, ra1;

        reset = 1'b1; init_en = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        last_rdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
`ifdef DMEM_ARB_RR_EN
        ref_pref = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0; init_en = 1'b0;

        // Reset state.
        check("rst_busy", 64'(busy), '0);
        check("rst_acks", 64'({p0_ack, p1_ack}), '0);
        check("rst_strobes", 64'({mem_MemRead, mem_MemWrite}), '0);
        check("rst_mem_address", mem_address, '0);
        check("rst_mem_write_data", mem_write_data, '0);
        check("rst_rdata", p0_rdata | p1_rdata, '0);

        // Port 0 write, then read back from the same address.
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 64'd100, '0, 64'h1122334455667788, '0);
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 64'd100, '0, '0, '0);
        check("t1_read_back", last_rdata, 64'h1122334455667788);

        // Simultaneous reads, twice, to exercise the arbitration order.
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 64'd16, 64'd24, '0, '0);
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 64'd16, 64'd24, '0, '0);

        // Port 1 write with scrambled pins, then read back through port 0.
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, '0, 64'd8, '0, 64'hDEAD_BEEF_0000_0001);
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 64'd8, '0, '0, '0);
        check("t4_read_back", last_rdata, 64'hDEAD_BEEF_0000_0001);

        // Reset in the middle of a read.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 64'd40;
        @(posedge clk); @(negedge clk);
        if (LAT > 0) begin
            @(posedge clk); @(negedge clk);
        end
        check("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1; p0_req = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 64'(busy), '0);
        check("mid_rst_acks", 64'({p0_ack, p1_ack}), '0);
        check("mid_rst_strobes", 64'({mem_MemRead, mem_MemWrite}), '0);
        check("mid_rst_mem_address", mem_address, '0);

        // A write requested in the same cycle as reset is never committed.
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 64'd200; p1_wdata = 64'h5555_AAAA_5555_AAAA;
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; p1_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("post_rst_quiet", 64'({busy, p0_ack, p1_ack, mem_MemWrite}), '0);
        end
        check("aborted_write_mem", mem_arr[200], ref_mem[200]);
`ifdef DMEM_ARB_RR_EN
        ref_pref = 1'b0;
`endif
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 64'd40, '0, '0, '0);

        // Randomized mix of single and simultaneous requests.
        for (int n = 0; n < 60; n++) begin
            sel = 2'($urandom_range(1, 3));
            ra0 = 64'($urandom_range(0, 31)) << 3;
            ra1 = 64'($urandom_range(0, 31)) << 3;
            run_txn(sel[0], sel[1], 1'($urandom), 1'($urandom), ra0, ra1,
                    {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
